// File: rtl/grav_pkg.sv
// rtl/grav_pkg.sv - shared types and regfile offsets for the Euler integrator
package grav_pkg;

  // Default configuration of the integrator.
  localparam int MAX_BODIES_DEF = 10;
  localparam int DT_SHIFT_DEF   = 4;
  localparam int ADDR_W_DEF     = 7;

  typedef logic signed [31:0] q16_t;
  typedef logic [6:0]         idx_t;

  // Regfile base indices; body i of a quantity lives at OFFSET + i (i = 1..MAX_BODIES).
  localparam idx_t OFFSET_POS_X = 7'd23;
  localparam idx_t OFFSET_POS_Y = 7'd33;
  localparam idx_t OFFSET_POS_Z = 7'd43;
  localparam idx_t OFFSET_VEL_X = 7'd53;
  localparam idx_t OFFSET_VEL_Y = 7'd63;
  localparam idx_t OFFSET_VEL_Z = 7'd73;
  localparam idx_t OFFSET_ACC_X = 7'd83;
  localparam idx_t OFFSET_ACC_Y = 7'd93;
  localparam idx_t OFFSET_ACC_Z = 7'd103;

  localparam idx_t OFFSET_POS [3] = '{OFFSET_POS_X, OFFSET_POS_Y, OFFSET_POS_Z};
  localparam idx_t OFFSET_VEL [3] = '{OFFSET_VEL_X, OFFSET_VEL_Y, OFFSET_VEL_Z};
  localparam idx_t OFFSET_ACC [3] = '{OFFSET_ACC_X, OFFSET_ACC_Y, OFFSET_ACC_Z};

  // Regfile port access width: none, addresses 1-3, or addresses 1-6.
  typedef enum logic [1:0] {
    RW_NONE = 2'd0,
    RW_LO   = 2'd1,
    RW_ALL  = 2'd3
  } rw_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_VA,
    RD_P,
    WB,
    CLR,
    DONE
  } state_e;

endpackage

// File: rtl/grav_axis_euler.sv
// rtl/grav_axis_euler.sv - one-axis explicit Euler update (combinational)
//  Ports: v, a, p in (Q16.16) -> v_new = v + a>>>DT_SHIFT, p_new = p + v_new>>>DT_SHIFT.
//  Arithmetic wraps; the shift is arithmetic so signs are preserved.
module grav_axis_euler
  import grav_pkg::*;
#(
  parameter int DT_SHIFT = DT_SHIFT_DEF
) (
  input  q16_t v,
  input  q16_t a,
  input  q16_t p,
  output q16_t v_new,
  output q16_t p_new
);

  assign v_new = v + (a >>> DT_SHIFT);
  assign p_new = p + (v_new >>> DT_SHIFT);

endmodule

// File: rtl/grav_step_integrator.sv
// rtl/grav_step_integrator.sv - per-frame Euler step over all bodies via the regfile port
//  Ports: CLK, RESET_N (async, active-low), FSM_START (level, rising edge starts a pass),
//  PLANET_NUM (body count, clamped to MAX_BODIES), FSM_re/FSM_we (0 none, 1 addr 1-3, 3 addr 1-6),
//  ADDR1..6 / DATA1..6 to the regfile, DATA1in..6in registered read data (valid the cycle after re),
//  clear_accs (one-cycle accumulator clear), FSM_DONE (high from pass end to next accepted start).
//  Optional feature macro: ACC_CLEAR_EN enables the clear_accs pulse.
module grav_step_integrator
  import grav_pkg::*;
#(
  parameter int MAX_BODIES = MAX_BODIES_DEF,
  parameter int DT_SHIFT   = DT_SHIFT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FSM_START,
  input  logic [6:0]        PLANET_NUM,
  output logic [1:0]        FSM_re,
  output logic [1:0]        FSM_we,
  output logic [ADDR_W-1:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6,
  output logic [31:0]       DATA1, DATA2, DATA3, DATA4, DATA5, DATA6,
  input  logic [31:0]       DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in,
  output logic              clear_accs,
  output logic              FSM_DONE
);

  localparam idx_t MAX_IDX = idx_t'(MAX_BODIES);

  state_e            state_q, state_d;
  logic              start_q;
  idx_t              i_q, i_d, n_q, n_d;
  rw_e               re_q, re_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q [6];
  logic [ADDR_W-1:0] addr_d [6];
  q16_t              data_lo_q [3];
  q16_t              data_lo_d [3];
  logic              clear_q, clear_d, done_q, done_d;

  q16_t din [6];
  q16_t v_in [3];
  q16_t a_in [3];
  q16_t v_new [3];
  q16_t p_new [3];

  assign din[0] = DATA1in;
  assign din[1] = DATA2in;
  assign din[2] = DATA3in;
  assign din[3] = DATA4in;
  assign din[4] = DATA5in;
  assign din[5] = DATA6in;

  // In RD_P the read port carries v and a; in WB it carries p, and the velocity
  // latched in RD_P is fed back with a zero acceleration so v_new passes it through.
  for (genvar g = 0; g < 3; g++) begin : g_axis
    assign v_in[g] = (state_q == WB) ? data_lo_q[g] : din[g];
    assign a_in[g] = (state_q == WB) ? '0 : din[g+3];
    grav_axis_euler #(.DT_SHIFT(DT_SHIFT)) u_axis (
      .v(v_in[g]), .a(a_in[g]), .p(din[g]), .v_new(v_new[g]), .p_new(p_new[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    n_d       = n_q;
    re_d      = RW_NONE;
    we_d      = RW_NONE;
    addr_d    = '{default: '0};
    data_lo_d = '{default: '0};
    done_d    = done_q;
    clear_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (FSM_START && !start_q) begin
          done_d = 1'b0;
          n_d    = (PLANET_NUM > MAX_IDX) ? MAX_IDX : PLANET_NUM;
          if (n_d == '0) begin
            state_d = DONE;
          end else begin
            i_d     = 7'd1;
            state_d = RD_VA;
            re_d    = RW_ALL;
            for (int k = 0; k < 3; k++) begin
              addr_d[k]   = ADDR_W'(OFFSET_VEL[k] + i_d);
              addr_d[k+3] = ADDR_W'(OFFSET_ACC[k] + i_d);
            end
          end
        end
      end
      RD_VA: begin
        state_d = RD_P;
        re_d    = RW_LO;
        for (int k = 0; k < 3; k++) addr_d[k] = ADDR_W'(OFFSET_POS[k] + i_q);
      end
      RD_P: begin
        state_d = WB;
        we_d    = RW_ALL;
        for (int k = 0; k < 3; k++) begin
          addr_d[k]    = ADDR_W'(OFFSET_VEL[k] + i_q);
          addr_d[k+3]  = ADDR_W'(OFFSET_POS[k] + i_q);
          data_lo_d[k] = v_new[k];
        end
      end
      WB: begin
        if (i_q == n_q) begin
          state_d = CLR;
        end else begin
          i_d     = i_q + 7'd1;
          state_d = RD_VA;
          re_d    = RW_ALL;
          for (int k = 0; k < 3; k++) begin
            addr_d[k]   = ADDR_W'(OFFSET_VEL[k] + i_d);
            addr_d[k+3] = ADDR_W'(OFFSET_ACC[k] + i_d);
          end
        end
      end
      CLR: begin
        state_d = DONE;
`ifdef ACC_CLEAR_EN
        clear_d = 1'b1;  // registered: visible during DONE, right before FSM_DONE rises
`else
        clear_d = 1'b0;
`endif
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      i_q       <= '0;
      n_q       <= '0;
      re_q      <= RW_NONE;
      we_q      <= RW_NONE;
      addr_q    <= '{default: '0};
      data_lo_q <= '{default: '0};
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= FSM_START;
      i_q       <= i_d;
      n_q       <= n_d;
      re_q      <= re_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_lo_q <= data_lo_d;
      clear_q   <= clear_d;
      done_q    <= done_d;
    end
  end

  assign FSM_re     = re_q;
  assign FSM_we     = we_q;
  assign ADDR1      = addr_q[0];
  assign ADDR2      = addr_q[1];
  assign ADDR3      = addr_q[2];
  assign ADDR4      = addr_q[3];
  assign ADDR5      = addr_q[4];
  assign ADDR6      = addr_q[5];
  assign DATA1      = data_lo_q[0];
  assign DATA2      = data_lo_q[1];
  assign DATA3      = data_lo_q[2];
  // Position only arrives on the read port during WB, so the new position is
  // produced combinationally in that cycle and held at zero otherwise.
  assign DATA4      = (we_q == RW_ALL) ? p_new[0] : '0;
  assign DATA5      = (we_q == RW_ALL) ? p_new[1] : '0;
  assign DATA6      = (we_q == RW_ALL) ? p_new[2] : '0;
  assign clear_accs = clear_q;
  assign FSM_DONE   = done_q;

endmodule
